// File: rtl/rbus_pkg.sv
// Shared rbus definitions: header mode encodings, packet-length helper and arbiter enums.
// Imported by the rbus arbiters and the header decoder.
package rbus_pkg;

  localparam int RBUS_DW      = 72;
  localparam int RBUS_LEN_BIT = 39;

  localparam logic [1:0] RBUS_RD1 = 2'b00;
  localparam logic [1:0] RBUS_RD8 = 2'b01;
  localparam logic [1:0] RBUS_WRA = 2'b10;
  localparam logic [1:0] RBUS_UPD = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OFFER,
    ARB_XFER,
    ARB_GAP
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } rbus_port_e;

  // Read requests are header-only; writes/updates carry 1 or 8 payload words.
  function automatic logic [3:0] rbus_pkt_words(input logic [1:0] mode, input logic len);
    logic [3:0] words;
    case (mode)
      RBUS_WRA, RBUS_UPD: words = len ? 4'd9 : 4'd2;
      default:            words = 4'd1;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/rbus_pkt_len.sv
// Combinational rbus header decode: total packet words and long-packet flag.
// Only the mode field and the length bit of the header are looked at.
module rbus_pkt_len
  import rbus_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       len_bit,
  output logic [3:0] words,
  output logic       is_long
);

  always_comb begin
    words   = rbus_pkt_words(mode, len_bit);
    is_long = (words == 4'd9);
  end

endmodule

// File: rtl/rbus_arb2.sv
// Two-port packet-atomic round-robin arbiter in front of one rbus slave port.
// Accepted words are forwarded through a single register stage; protocol violations are dropped.
module rbus_arb2
  import rbus_pkg::*;
#(
  parameter int OFFER_TMO = 16,
  parameter int GAP_CYC   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_stb,
  input  logic               a_sof,
  input  logic [RBUS_DW-1:0] a_data,
  output logic [1:0]         a_rdy,
  input  logic               b_stb,
  input  logic               b_sof,
  input  logic [RBUS_DW-1:0] b_data,
  output logic [1:0]         b_rdy,
  output logic               o_stb,
  output logic               o_sof,
  output logic [RBUS_DW-1:0] o_data,
  input  logic [1:0]         o_rdy,
  output logic [1:0]         o_err
);

  localparam int TMO_W = $clog2(OFFER_TMO);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(OFFER_TMO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  arb_state_e         state_q, state_d;
  rbus_port_e         prio_q, prio_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               stb_q, stb_d;
  logic               sof_q, sof_d;
  logic [RBUS_DW-1:0] data_q, data_d;
  logic [1:0]         err_q, err_d;

  logic               g_stb;
  logic               g_sof;
  logic [RBUS_DW-1:0] g_data;
  logic               g_err;
  logic [3:0]         pkt_words;
  logic               pkt_long;
  rbus_port_e         prio_other;

  // The priority port doubles as the granted port while in OFFER/XFER.
  assign g_stb      = (prio_q == PORT_B) ? b_stb  : a_stb;
  assign g_sof      = (prio_q == PORT_B) ? b_sof  : a_sof;
  assign g_data     = (prio_q == PORT_B) ? b_data : a_data;
  assign prio_other = (prio_q == PORT_B) ? PORT_A : PORT_B;

  rbus_pkt_len u_pkt_len (
    .mode    (g_data[1:0]),
    .len_bit (g_data[RBUS_LEN_BIT]),
    .words   (pkt_words),
    .is_long (pkt_long)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    wcnt_d  = wcnt_q;
    stb_d   = 1'b0;
    sof_d   = 1'b0;
    data_d  = data_q;
    err_d   = 2'b00;
    g_err   = 1'b0;
    a_rdy   = 2'b00;
    b_rdy   = 2'b00;

    case (state_q)
      ARB_IDLE: begin
        g_err = g_stb;
        if (o_rdy != 2'b00) begin
          state_d = ARB_OFFER;
          tmo_d   = '0;
        end
      end
      ARB_OFFER: begin
        if (prio_q == PORT_B) b_rdy = o_rdy;
        else                  a_rdy = o_rdy;
        // A header arriving on the expiry cycle still wins the grant.
        if (g_stb && g_sof) begin
          stb_d  = 1'b1;
          sof_d  = 1'b1;
          data_d = g_data;
          if (pkt_words == 4'd1) begin
            state_d = ARB_GAP;
            gap_d   = '0;
            prio_d  = prio_other;
          end else begin
            state_d = ARB_XFER;
            wcnt_d  = pkt_long ? 4'd8 : 4'd1;
          end
        end else begin
          g_err = g_stb;
          if (tmo_q == TMO_LAST) begin
            state_d = ARB_IDLE;
            prio_d  = prio_other;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      ARB_XFER: begin
        if (g_stb) begin
          if (g_sof) begin
            g_err = 1'b1;
          end else begin
            stb_d  = 1'b1;
            data_d = g_data;
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) begin
              state_d = ARB_GAP;
              gap_d   = '0;
              prio_d  = prio_other;
            end
          end
        end
      end
      ARB_GAP: begin
        g_err = g_stb;
        if (gap_q == GAP_LAST) state_d = ARB_IDLE;
        else                   gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = ARB_IDLE;
    endcase

    // The non-granted port may never strobe.
    if (prio_q == PORT_B) begin
      err_d[1] = g_err;
      err_d[0] = a_stb;
    end else begin
      err_d[0] = g_err;
      err_d[1] = b_stb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      prio_q  <= PORT_A;
      tmo_q   <= '0;
      gap_q   <= '0;
      wcnt_q  <= '0;
      stb_q   <= 1'b0;
      sof_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      wcnt_q  <= wcnt_d;
      stb_q   <= stb_d;
      sof_q   <= sof_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign o_stb  = stb_q;
  assign o_sof  = sof_q;
  assign o_data = data_q;
  assign o_err  = err_q;

endmodule
